toggle_sequence_checker: RTL and testbench

- Receiver-side checker for the 2-bit one-hot toggle sequence (01 -> 10 -> 01 ...) produced by the toggle next-state generator.
- Samples Toggle on clock edges where EN is high, acquires lock on the alternating pattern, then flags repeats and illegal codes.
- Keeps saturating counts of good transitions and errors.
- Sits downstream of the generator as a protocol monitor and health indicator.

---
 rtl/toggle_sequence_checker.sv | 154 +++++++++++++++
 tb/tb_toggle_sequence_checker.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/toggle_sequence_checker.sv
// Receiver-side monitor for the 01/10 one-hot toggle sequence: acquires lock on the
// alternating pattern, flags repeats and illegal codes, and keeps saturating counters.
module toggle_sequence_checker #(
    parameter int LOCK_COUNT = 2,
    parameter int TCNT_W     = 16,
    parameter int ECNT_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              EN,
    input  logic [1:0]        Toggle,
    input  logic              Clear,
    output logic              Locked,
    output logic [1:0]        ExpectedToggle,
    output logic              ErrPulse,
    output logic              IllegalPulse,
    output logic [TCNT_W-1:0] ToggleCount,
    output logic [ECNT_W-1:0] ErrCount
);

    localparam logic [1:0] S_IDLE    = 2'b00;
    localparam logic [1:0] S_ACQUIRE = 2'b01;
    localparam logic [1:0] S_LOCKED  = 2'b10;
    localparam logic [3:0] LOCK_U    = 4'(LOCK_COUNT);

    logic [1:0]        state_q, state_d;
    logic [1:0]        last_q, last_d;
    logic [3:0]        run_q, run_d;
    logic [TCNT_W-1:0] tcnt_q, tcnt_d;
    logic [ECNT_W-1:0] ecnt_q, ecnt_d;
    logic              err_q, err_d;
    logic              ill_q, ill_d;
    logic              tinc, einc;

    logic       legal;
    logic       is_flip;
    logic [3:0] run_inc;

    assign legal   = Toggle[0] ^ Toggle[1];
    assign is_flip = (Toggle == {last_q[0], last_q[1]});
    assign run_inc = run_q + 4'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            last_q  <= 2'b00;
            run_q   <= 4'd0;
            tcnt_q  <= '0;
            ecnt_q  <= '0;
            err_q   <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            run_q   <= run_d;
            tcnt_q  <= tcnt_d;
            ecnt_q  <= ecnt_d;
            err_q   <= err_d;
            ill_q   <= ill_d;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        run_d   = run_q;
        case (state_q)
            S_IDLE: begin
                if (EN && legal) begin
                    state_d = S_ACQUIRE;
                    last_d  = Toggle;
                    run_d   = 4'd0;
                end
            end
            S_ACQUIRE: begin
                if (EN) begin
                    if (!legal) begin
                        state_d = S_IDLE;
                    end else if (is_flip) begin
                        last_d = Toggle;
                        if (run_inc == LOCK_U) begin
                            state_d = S_LOCKED;
                            run_d   = 4'd0;
                        end else begin
                            run_d = run_inc;
                        end
                    end else begin
                        run_d = 4'd0;
                    end
                end
            end
            S_LOCKED: begin
                if (EN) begin
                    if (!legal) begin
                        state_d = S_IDLE;
                    end else if (is_flip) begin
                        last_d = Toggle;
                    end else begin
                        state_d = S_ACQUIRE;
                        run_d   = 4'd0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Pulses and counter increments; Clear overrides any increment on the same edge.
    always_comb begin
        err_d = 1'b0;
        ill_d = 1'b0;
        tinc  = 1'b0;
        einc  = 1'b0;
        if (EN) begin
            case (state_q)
                S_IDLE, S_ACQUIRE: begin
                    if (!legal) begin
                        ill_d = 1'b1;
                        einc  = 1'b1;
                    end
                end
                S_LOCKED: begin
                    if (!legal) begin
                        err_d = 1'b1;
                        ill_d = 1'b1;
                        einc  = 1'b1;
                    end else if (is_flip) begin
                        tinc = 1'b1;
                    end else begin
                        err_d = 1'b1;
                        einc  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        if (Clear) begin
            tcnt_d = '0;
            ecnt_d = '0;
        end else begin
            tcnt_d = (tinc && !(&tcnt_q)) ? tcnt_q + TCNT_W'(1) : tcnt_q;
            ecnt_d = (einc && !(&ecnt_q)) ? ecnt_q + ECNT_W'(1) : ecnt_q;
        end
    end

    assign Locked         = (state_q == S_LOCKED);
    assign ExpectedToggle = ((state_q == S_ACQUIRE) || (state_q == S_LOCKED)) ?
                            {last_q[0], last_q[1]} : 2'b01;
    assign ErrPulse       = err_q;
    assign IllegalPulse   = ill_q;
    assign ToggleCount    = tcnt_q;
    assign ErrCount       = ecnt_q;

endmodule

// File: tb/tb_toggle_sequence_checker.sv
// Bench for toggle_sequence_checker: directed scenarios plus randomized stimulus against
// a rule-level reference model; a second instance with a 2-bit error counter covers saturation.
module tb_toggle_sequence_checker;

    localparam int LOCK = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic       clr = 1'b0;
    logic [1:0] tog = 2'b00;

    logic        locked, errp, illp;
    logic [1:0]  exp_t;
    logic [15:0] tcnt;
    logic [7:0]  ecnt;
    logic        s_locked, s_errp, s_illp;
    logic [1:0]  s_exp;
    logic [15:0] s_tcnt;
    logic [1:0]  s_ecnt;

    int checks = 0;
    int errors = 0;

    // Reference model state: mode 0=idle, 1=acquiring, 2=locked
    int         m_mode = 0;
    logic [1:0] m_last = 2'b00;
    int         m_run = 0, m_tcnt = 0, m_ecnt = 0, m_ecnt_s = 0;
    bit         m_err = 0, m_ill = 0;

    toggle_sequence_checker #(.LOCK_COUNT(LOCK), .TCNT_W(16), .ECNT_W(8)) dut (
        .clk(clk), .rst(rst), .EN(en), .Toggle(tog), .Clear(clr),
        .Locked(locked), .ExpectedToggle(exp_t), .ErrPulse(errp), .IllegalPulse(illp),
        .ToggleCount(tcnt), .ErrCount(ecnt)
    );

    toggle_sequence_checker #(.LOCK_COUNT(LOCK), .TCNT_W(16), .ECNT_W(2)) dut_s (
        .clk(clk), .rst(rst), .EN(en), .Toggle(tog), .Clear(clr),
        .Locked(s_locked), .ExpectedToggle(s_exp), .ErrPulse(s_errp), .IllegalPulse(s_illp),
        .ToggleCount(s_tcnt), .ErrCount(s_ecnt)
    );

    task automatic model_update(input bit r, input bit e, input logic [1:0] t, input bit c);
        bit legal, inc_t, inc_e;
        legal = (t == 2'b01) || (t == 2'b10);
        m_err = 0; m_ill = 0; inc_t = 0; inc_e = 0;
        if (r) begin
            m_mode = 0; m_last = 2'b00; m_run = 0;
            m_tcnt = 0; m_ecnt = 0; m_ecnt_s = 0;
        end else begin
            if (e) begin
                if (!legal) begin
                    m_ill = 1; inc_e = 1;
                    if (m_mode == 2) m_err = 1;
                    m_mode = 0;
                end else if (m_mode == 0) begin
                    m_last = t; m_run = 0; m_mode = 1;
                end else if (t == m_last) begin
                    if (m_mode == 2) begin m_err = 1; inc_e = 1; end
                    m_run = 0; m_mode = 1;
                end else begin
                    m_last = t;
                    if (m_mode == 2) inc_t = 1;
                    else begin
                        m_run = m_run + 1;
                        if (m_run == LOCK) begin m_mode = 2; m_run = 0; end
                    end
                end
            end
            if (c) begin
                m_tcnt = 0; m_ecnt = 0; m_ecnt_s = 0;
            end else begin
                if (inc_t && m_tcnt < 65535) m_tcnt++;
                if (inc_e && m_ecnt < 255) m_ecnt++;
                if (inc_e && m_ecnt_s < 3) m_ecnt_s++;
            end
        end
    endtask

    task automatic step(input bit r, input bit e, input logic [1:0] t, input bit c);
        @(negedge clk);
        rst = r; en = e; tog = t; clr = c;
        @(posedge clk);
        model_update(r, e, t, c);
        #1;
        $display("txn rst=%0b en=%0b tog=%b clr=%0b -> locked=%0b exp=%b err=%0b ill=%0b tcnt=%0d ecnt=%0d ecnt_s=%0d",
                 r, e, t, c, locked, exp_t, errp, illp, tcnt, ecnt, s_ecnt);
    endtask

    task automatic test_reset();
        step(1, 0, 2'b00, 0);
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b want 0", locked); end
        checks++; if (exp_t !== 2'b01) begin errors++; $display("FAIL reset_expected: got %b want 01", exp_t); end
        checks++; if ({errp, illp} !== 2'b00) begin errors++; $display("FAIL reset_pulses: got %b want 00", {errp, illp}); end
        checks++; if (tcnt !== 16'd0 || ecnt !== 8'd0 || s_ecnt !== 2'd0) begin
            errors++; $display("FAIL reset_counts: got tcnt=%0d ecnt=%0d ecnt_s=%0d want 0", tcnt, ecnt, s_ecnt);
        end
    endtask

    task automatic test_lock_acquire();
        step(1, 0, 2'b00, 0);
        step(0, 1, 2'b01, 0);
        checks++; if (locked !== 1'b0 || exp_t !== 2'b10) begin
            errors++; $display("FAIL acquire_first: got locked=%b exp=%b want 0/10", locked, exp_t);
        end
        step(0, 1, 2'b10, 0);
        step(0, 1, 2'b01, 0);
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL acquire_lock: got %b want 1", locked); end
        step(0, 1, 2'b10, 0);
        checks++; if (tcnt !== 16'd1 || exp_t !== 2'b01) begin
            errors++; $display("FAIL locked_count: got tcnt=%0d exp=%b want 1/01", tcnt, exp_t);
        end
        checks++; if ({errp, illp} !== 2'b00 || ecnt !== 8'd0) begin
            errors++; $display("FAIL lock_no_errors: got pulses=%b ecnt=%0d want 00/0", {errp, illp}, ecnt);
        end
    endtask

    task automatic test_repeat_error();
        step(0, 1, 2'b10, 0);
        checks++; if ({errp, illp} !== 2'b10 || ecnt !== 8'd1 || locked !== 1'b0) begin
            errors++; $display("FAIL repeat_err: got err/ill=%b ecnt=%0d locked=%b want 10/1/0", {errp, illp}, ecnt, locked);
        end
        step(0, 0, 2'b10, 0);
        checks++; if (errp !== 1'b0) begin errors++; $display("FAIL repeat_one_cycle: got %b want 0", errp); end
        step(0, 1, 2'b01, 0);
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reacquire_early: got %b want 0", locked); end
        step(0, 1, 2'b10, 0);
        checks++; if (locked !== 1'b1 || tcnt !== 16'd1) begin
            errors++; $display("FAIL reacquire_lock: got locked=%b tcnt=%0d want 1/1", locked, tcnt);
        end
    endtask

    task automatic test_illegal();
        step(1, 0, 2'b00, 0);
        step(0, 1, 2'b01, 0); step(0, 1, 2'b10, 0); step(0, 1, 2'b01, 0);
        step(0, 1, 2'b11, 0);
        checks++; if ({errp, illp} !== 2'b11 || ecnt !== 8'd1) begin
            errors++; $display("FAIL locked_illegal: got err/ill=%b ecnt=%0d want 11/1", {errp, illp}, ecnt);
        end
        checks++; if (locked !== 1'b0 || exp_t !== 2'b01) begin
            errors++; $display("FAIL illegal_to_idle: got locked=%b exp=%b want 0/01", locked, exp_t);
        end
        step(0, 1, 2'b00, 0);
        checks++; if ({errp, illp} !== 2'b01 || ecnt !== 8'd2 || exp_t !== 2'b01) begin
            errors++; $display("FAIL idle_illegal: got err/ill=%b ecnt=%0d exp=%b want 01/2/01", {errp, illp}, ecnt, exp_t);
        end
    endtask

    task automatic test_en_gating();
        logic [1:0] last;
        int         want_t;
        step(1, 0, 2'b00, 0);
        step(0, 1, 2'b01, 0); step(0, 1, 2'b10, 0); step(0, 1, 2'b01, 0);
        last = 2'b01; want_t = 0;
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) begin
                last = {last[0], last[1]};
                want_t++;
                step(0, 1, last, 0);
            end else begin
                step(0, 0, 2'($urandom_range(0, 3)), 0);
            end
            checks++; if ({errp, illp} !== 2'b00 || locked !== 1'b1 || tcnt !== 16'(want_t)) begin
                errors++; $display("FAIL en_gating[%0d]: got pulses=%b locked=%b tcnt=%0d want 00/1/%0d",
                                   i, {errp, illp}, locked, tcnt, want_t);
            end
        end
    endtask

    task automatic test_saturation();
        int want_s;
        step(1, 0, 2'b00, 0);
        for (int i = 1; i <= 5; i++) begin
            step(0, 1, (i % 2 == 1) ? 2'b00 : 2'b11, 0);
            want_s = (i < 3) ? i : 3;
            checks++; if (s_ecnt !== 2'(want_s) || ecnt !== 8'(i) || illp !== 1'b1) begin
                errors++; $display("FAIL err_saturate[%0d]: got ecnt_s=%0d ecnt=%0d ill=%b want %0d/%0d/1",
                                   i, s_ecnt, ecnt, illp, want_s, i);
            end
        end
        step(0, 0, 2'b11, 0);
        checks++; if (s_ecnt !== 2'd3) begin errors++; $display("FAIL err_saturate_hold: got %0d want 3", s_ecnt); end
    endtask

    task automatic test_clear();
        step(1, 0, 2'b00, 0);
        step(0, 1, 2'b01, 0); step(0, 1, 2'b10, 0); step(0, 1, 2'b01, 0); step(0, 1, 2'b10, 0);
        step(0, 1, 2'b01, 1);
        checks++; if (tcnt !== 16'd0 || locked !== 1'b1 || exp_t !== 2'b10) begin
            errors++; $display("FAIL clear_good: got tcnt=%0d locked=%b exp=%b want 0/1/10", tcnt, locked, exp_t);
        end
        step(0, 1, 2'b10, 0);
        checks++; if (tcnt !== 16'd1) begin errors++; $display("FAIL clear_resume: got %0d want 1", tcnt); end
        step(0, 1, 2'b10, 1);
        checks++; if (errp !== 1'b1 || ecnt !== 8'd0 || locked !== 1'b0) begin
            errors++; $display("FAIL clear_vs_error: got err=%b ecnt=%0d locked=%b want 1/0/0", errp, ecnt, locked);
        end
    endtask

    task automatic test_reset_mid();
        step(1, 0, 2'b00, 0);
        step(0, 1, 2'b00, 0);
        step(0, 1, 2'b01, 0); step(0, 1, 2'b10, 0); step(0, 1, 2'b01, 0);
        for (int i = 0; i < 7; i++) step(0, 1, (i % 2 == 0) ? 2'b10 : 2'b01, 0);
        checks++; if (tcnt !== 16'd7 || ecnt !== 8'd1 || locked !== 1'b1) begin
            errors++; $display("FAIL pre_reset: got tcnt=%0d ecnt=%0d locked=%b want 7/1/1", tcnt, ecnt, locked);
        end
        step(1, 1, 2'b01, 0);
        checks++; if ({locked, exp_t, errp, illp} !== 5'b00100 || tcnt !== 16'd0 || ecnt !== 8'd0) begin
            errors++; $display("FAIL mid_reset: got locked=%b exp=%b err=%b ill=%b tcnt=%0d ecnt=%0d want 0/01/0/0/0/0",
                               locked, exp_t, errp, illp, tcnt, ecnt);
        end
        step(0, 1, 2'b10, 0);
        checks++; if (locked !== 1'b0 || exp_t !== 2'b01 || {errp, illp} !== 2'b00) begin
            errors++; $display("FAIL post_reset_acquire: got locked=%b exp=%b pulses=%b want 0/01/00", locked, exp_t, {errp, illp});
        end
        step(0, 1, 2'b01, 0); step(0, 1, 2'b10, 0);
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL post_reset_lock: got %b want 1", locked); end
    endtask

    task automatic test_random();
        logic [1:0]  drv, t;
        logic [51:0] act, want;
        int          r;
        drv = 2'b01;
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            if (r < 70) begin drv = {drv[0], drv[1]}; t = drv; end
            else if (r < 85) t = drv;
            else t = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
            step(($urandom_range(0, 99) < 1), ($urandom_range(0, 99) < 80), t, ($urandom_range(0, 99) < 3));
            want = {(m_mode == 2), ((m_mode == 0) ? 2'b01 : {m_last[0], m_last[1]}), m_err, m_ill,
                    16'(m_tcnt), 8'(m_ecnt),
                    (m_mode == 2), ((m_mode == 0) ? 2'b01 : {m_last[0], m_last[1]}), m_err, m_ill,
                    16'(m_tcnt), 2'(m_ecnt_s)};
            act  = {locked, exp_t, errp, illp, tcnt, ecnt, s_locked, s_exp, s_errp, s_illp, s_tcnt, s_ecnt};
            checks++; if (act !== want) begin
                errors++; $display("FAIL random[%0d]: got %h want %h", i, act, want);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_lock_acquire();
        test_repeat_error();
        test_illegal();
        test_en_gating();
        test_saturation();
        test_clear();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
